// File: rtl/sum_acc_pkg.sv
// Shared types and helpers for the lane-sum accumulator.
// State encodings and a constant clog2 for parameter sizing.
package sum_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sum_lane_reduce.sv
// Combinational cross-lane reduction of one beat of lane sums.
// Lanes are zero-extended to ACC_WIDTH before adding.
module sum_lane_reduce #(
    parameter int WIDTH     = 8,
    parameter int LANES     = 2,
    parameter int ACC_WIDTH = 16
) (
    input  logic [LANES*WIDTH-1:0] in_sum,
    output logic [ACC_WIDTH-1:0]   sum
);

    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++) begin
            sum = sum + ACC_WIDTH'(in_sum[i*WIDTH +: WIDTH]);
        end
    end

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates BEATS beats of reduced lane sums into a saturating
// frame total and hands it off over a valid/ready port.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LANES     = 2,
    parameter int BEATS     = 4,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_W     = clog2(BEATS + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_sum,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_total,
    output logic [CNT_W-1:0]       out_count,
    output logic                   out_ovf
);

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;
    localparam logic [CNT_W-1:0]     LAST    = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]     ONE     = CNT_W'(1);

    state_t               state, state_n;
    logic [ACC_WIDTH-1:0] acc, acc_n;
    logic [ACC_WIDTH-1:0] beat_sum, acc_sat, tot_n;
    logic [ACC_WIDTH:0]   wide;
    logic [CNT_W-1:0]     cnt, cnt_n, cnt_inc, ocnt_n;
    logic                 ovf, ovf_n, oovf_n;
    logic                 accept, clamp;

    sum_lane_reduce #(
        .WIDTH    (WIDTH),
        .LANES    (LANES),
        .ACC_WIDTH(ACC_WIDTH)
    ) u_reduce (
        .in_sum(in_sum),
        .sum   (beat_sum)
    );

    assign accept  = in_valid && in_ready;
    assign wide    = {1'b0, acc} + {1'b0, beat_sum};
    assign clamp   = wide[ACC_WIDTH];
    assign acc_sat = clamp ? ACC_MAX : wide[ACC_WIDTH-1:0];
    assign cnt_inc = cnt + ONE;

    // Handshake flags decode straight from the state register.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == EMIT);

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        ovf_n   = ovf;
        tot_n   = out_total;
        ocnt_n  = out_count;
        oovf_n  = out_ovf;
        unique case (state)
            ACCUM: begin
                if (accept) begin
                    acc_n = acc_sat;
                    cnt_n = cnt_inc;
                    ovf_n = ovf | clamp;
                    if (cnt == LAST || flush) begin
                        state_n = EMIT;
                        tot_n   = acc_sat;
                        ocnt_n  = cnt_inc;
                        oovf_n  = ovf | clamp;
                    end
                end else if (flush && cnt != '0) begin
                    state_n = EMIT;
                    tot_n   = acc;
                    ocnt_n  = cnt;
                    oovf_n  = ovf;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    state_n = ACCUM;
                    acc_n   = '0;
                    cnt_n   = '0;
                    ovf_n   = 1'b0;
                end
            end
            default: state_n = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_total <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            ovf       <= ovf_n;
            out_total <= tot_n;
            out_count <= ocnt_n;
            out_ovf   <= oovf_n;
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: a 16-bit and a 10-bit instance share
// stimulus and are checked against a plain-arithmetic frame model.
module tb_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_sum = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        rdy_a, vld_a, ovf_a;
    logic [15:0] tot_a;
    logic [2:0]  cnt_a;
    logic        rdy_b, vld_b, ovf_b;
    logic [9:0]  tot_b;
    logic [2:0]  cnt_b;

    int vectors = 0;
    int errors  = 0;

    int m_sum = 0;
    int m_n   = 0;

    always #5 clk = ~clk;

    sum_accumulator #(
        .WIDTH(8), .LANES(2), .BEATS(4), .ACC_WIDTH(16)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(rdy_a),
        .in_sum(in_sum), .flush(flush),
        .out_valid(vld_a), .out_ready(out_ready),
        .out_total(tot_a), .out_count(cnt_a), .out_ovf(ovf_a)
    );

    sum_accumulator #(
        .WIDTH(8), .LANES(2), .BEATS(4), .ACC_WIDTH(10)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(rdy_b),
        .in_sum(in_sum), .flush(flush),
        .out_valid(vld_b), .out_ready(out_ready),
        .out_total(tot_b), .out_count(cnt_b), .out_ovf(ovf_b)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int s, input int maxv);
        return (s > maxv) ? maxv : s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int a, input int b, input bit fl);
        in_valid = 1'b1;
        in_sum   = {b[7:0], a[7:0]};
        flush    = fl;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        m_sum += a + b;
        m_n++;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_vld_a"}, int'(vld_a), 0);
        chk({tag, "_rdy_a"}, int'(rdy_a), 1);
        chk({tag, "_vld_b"}, int'(vld_b), 0);
    endtask

    task automatic chk_emit(input string tag);
        chk({tag, "_vld_a"}, int'(vld_a), 1);
        chk({tag, "_rdy_a"}, int'(rdy_a), 0);
        chk({tag, "_tot_a"}, int'(tot_a), sat(m_sum, 65535));
        chk({tag, "_cnt_a"}, int'(cnt_a), m_n);
        chk({tag, "_ovf_a"}, int'(ovf_a), int'(m_sum > 65535));
        chk({tag, "_vld_b"}, int'(vld_b), 1);
        chk({tag, "_tot_b"}, int'(tot_b), sat(m_sum, 1023));
        chk({tag, "_cnt_b"}, int'(cnt_b), m_n);
        chk({tag, "_ovf_b"}, int'(ovf_b), int'(m_sum > 1023));
    endtask

    task automatic release_frame(input string tag, input int hold);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk_emit({tag, "_hold"});
            chk({tag, "_hold_rdy_b"}, int'(rdy_b), 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_idle({tag, "_rel"});
        m_sum = 0;
        m_n   = 0;
    endtask

    task automatic frame(input string tag, input int a, input int b,
                         input int n, input bit fl_last);
        for (int i = 0; i < n; i++) begin
            beat(a, b, fl_last && (i == n - 1));
            if (i != n - 1 && !(fl_last && i == n - 1))
                chk({tag, "_early_vld"}, int'(vld_a), 0);
        end
    endtask

    task automatic flush_only();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b, n, mode, hold;

        #1;
        chk("rst_vld_a", int'(vld_a), 0);
        chk("rst_rdy_a", int'(rdy_a), 1);
        chk("rst_tot_a", int'(tot_a), 0);
        chk("rst_cnt_a", int'(cnt_a), 0);
        chk("rst_ovf_a", int'(ovf_a), 0);
        repeat (2) tick();
        rst_n = 1'b1;

        frame("full", 150, 150, 4, 1'b0);
        chk_emit("full");
        release_frame("full", 0);

        frame("stall", 150, 150, 4, 1'b0);
        chk_emit("stall");
        release_frame("stall", 5);

        frame("fl2", 150, 150, 2, 1'b0);
        chk("fl2_pre", int'(vld_a), 0);
        flush_only();
        chk_emit("fl2");
        release_frame("fl2", 1);

        flush_only();
        chk_idle("fl0");
        tick();
        chk_idle("fl0b");

        frame("fl3", 150, 150, 3, 1'b1);
        chk_emit("fl3");
        release_frame("fl3", 0);
        tick();
        chk_idle("fl3_once");

        frame("sat", 255, 255, 4, 1'b0);
        chk_emit("sat");
        release_frame("sat", 0);
        frame("small", 1, 1, 4, 1'b0);
        chk_emit("small");
        release_frame("small", 0);

        frame("abort", 150, 150, 2, 1'b0);
        rst_n = 1'b0;
        #2;
        chk_idle("abort_rst");
        chk("abort_tot", int'(tot_a), 0);
        chk("abort_cnt", int'(cnt_a), 0);
        m_sum = 0;
        m_n   = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        frame("post", 150, 150, 4, 1'b0);
        chk_emit("post");
        release_frame("post", 0);

        for (int f = 0; f < 24; f++) begin
            n    = int'($urandom_range(1, 4));
            mode = int'($urandom_range(0, 2));
            hold = int'($urandom_range(0, 3));
            for (int i = 0; i < n; i++) begin
                a = int'($urandom_range(0, 255));
                b = int'($urandom_range(0, 255));
                beat(a, b, (mode == 1) && (i == n - 1));
                if (i != n - 1)
                    chk("rnd_mid_vld", int'(vld_a), 0);
            end
            if (n < 4 && mode != 1) begin
                chk("rnd_pre_flush", int'(vld_a), 0);
                flush_only();
            end
            chk_emit("rnd");
            release_frame("rnd", hold);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
